// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-cycle controller: keypad MM:SS entry, BCD countdown off a derived
// 1 s tick, magnetron enable with door interlock, and a timed end-of-cycle beep.
module microwave_timer_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned BEEP_SECS     = 3
) (
  input  logic        clk_100Hz,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        door_open,
  output logic [15:0] time_bcd,
  output logic        magnetron_on,
  output logic        beep,
  output logic [2:0]  state
);

  localparam int unsigned BEEP_CYCLES = BEEP_SECS * TICKS_PER_SEC;
  localparam int unsigned TW = $clog2(TICKS_PER_SEC);
  localparam int unsigned BW = $clog2(BEEP_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_r;
  logic [15:0]   time_r;
  logic [TW-1:0] tick_r;
  logic [BW-1:0] beep_cnt_r;
  logic          mag_r;
  logic          beep_r;

  logic key_ok_s;
  logic time_zero_s;

  // Borrow chain: seconds wrap to 59 (not 99) when a minute is borrowed.
  function automatic logic [15:0] bcd_dec_sec(input logic [15:0] t);
    logic [15:0] r;
    if (t[3:0] != 4'd0) begin
      r = {t[15:4], t[3:0] - 4'd1};
    end else if (t[7:4] != 4'd0) begin
      r = {t[15:8], t[7:4] - 4'd1, 4'd9};
    end else if (t[11:8] != 4'd0) begin
      r = {t[15:12], t[11:8] - 4'd1, 4'd5, 4'd9};
    end else begin
      r = {t[15:12] - 4'd1, 4'd9, 4'd5, 4'd9};
    end
    return r;
  endfunction

  assign key_ok_s    = key_valid && (key_digit <= 4'd9);
  assign time_zero_s = (time_r == 16'h0000);

  // Single-process FSM; outputs are registered with the next state.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      state_r    <= S_IDLE;
      time_r     <= 16'h0000;
      tick_r     <= '0;
      beep_cnt_r <= '0;
      mag_r      <= 1'b0;
      beep_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (key_ok_s) begin
            time_r  <= {12'h000, key_digit};
            state_r <= S_SET;
          end else begin
            time_r  <= 16'h0000;
          end
        end
        S_SET: begin
          if (stop) begin
            time_r  <= 16'h0000;
            state_r <= S_IDLE;
          end else if (start && !door_open && !time_zero_s) begin
            tick_r  <= '0;
            mag_r   <= 1'b1;
            state_r <= S_COOK;
          end else if (key_ok_s) begin
            time_r  <= {time_r[11:0], key_digit};
          end else begin
            time_r  <= time_r;
          end
        end
        S_COOK: begin
          // A pause request pre-empts a same-cycle wrap, so the tick stays at its last value.
          if (stop || door_open) begin
            mag_r   <= 1'b0;
            state_r <= S_PAUSE;
          end else if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            time_r  <= bcd_dec_sec(time_r);
            if (time_r == 16'h0001) begin
              mag_r      <= 1'b0;
              beep_r     <= 1'b1;
              beep_cnt_r <= '0;
              state_r    <= S_DONE;
            end else begin
              state_r    <= S_COOK;
            end
          end else begin
            tick_r  <= tick_r + TW'(1);
          end
        end
        S_PAUSE: begin
          if (stop) begin
            time_r  <= 16'h0000;
            state_r <= S_IDLE;
          end else if (start && !door_open) begin
            mag_r   <= 1'b1;
            state_r <= S_COOK;
          end else begin
            state_r <= S_PAUSE;
          end
        end
        S_DONE: begin
          if (stop || (beep_cnt_r == BEEP_LAST)) begin
            beep_r     <= 1'b0;
            beep_cnt_r <= '0;
            state_r    <= S_IDLE;
          end else begin
            beep_cnt_r <= beep_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r    <= S_IDLE;
          time_r     <= 16'h0000;
          tick_r     <= '0;
          beep_cnt_r <= '0;
          mag_r      <= 1'b0;
          beep_r     <= 1'b0;
        end
      endcase
    end
  end

  assign time_bcd     = time_r;
  assign magnetron_on = mag_r;
  assign beep         = beep_r;
  assign state        = state_r;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: vector table, hand-written timing sequences,
// then randomized stimulus against a minutes/seconds reference model.
module tb_microwave_timer_ctrl;
  localparam int TPS = 100;
  localparam int BS  = 3;

  logic        clk_100Hz = 1'b0;
  logic        rst, key_valid, start, stop, door_open;
  logic [3:0]  key_digit;
  logic [15:0] time_bcd;
  logic        magnetron_on, beep;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  microwave_timer_ctrl #(.TICKS_PER_SEC(TPS), .BEEP_SECS(BS)) dut (
    .clk_100Hz(clk_100Hz), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_open(door_open), .time_bcd(time_bcd),
    .magnetron_on(magnetron_on), .beep(beep), .state(state)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  // Apply inputs for one cycle; return 1 time unit after the edge that samples them.
  task automatic drive(input logic r, input logic k, input logic [3:0] d,
                       input logic s, input logic p, input logic dr);
    rst = r; key_valid = k; key_digit = d; start = s; stop = p; door_open = dr;
    @(posedge clk_100Hz);
    #1;
  endtask

  task automatic idle_n(input int n, input logic dr);
    repeat (n) drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, dr);
  endtask

  task automatic key(input logic [3:0] d);
    drive(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [2:0] es, input logic [15:0] et,
                     input logic em, input logic eb);
    checks++;
    if ({state, time_bcd, magnetron_on, beep} !== {es, et, em, eb}) begin
      failures++;
      $display("FAIL %s: got state=%0d time=%h mag=%b beep=%b, expected state=%0d time=%h mag=%b beep=%b",
               name, state, time_bcd, magnetron_on, beep, es, et, em, eb);
    end
  endtask

  // ---------------- reference model (minutes/seconds integers) ----------------
  int m_state, m_min, m_sec, m_phase, m_beep_left;

  function automatic logic [15:0] m_time();
    logic [15:0] t;
    t[15:12] = 4'(m_min / 10);
    t[11:8]  = 4'(m_min % 10);
    t[7:4]   = 4'(m_sec / 10);
    t[3:0]   = 4'(m_sec % 10);
    return t;
  endfunction

  task automatic m_clear();
    m_state = 0; m_min = 0; m_sec = 0; m_phase = 0; m_beep_left = 0;
  endtask

  task automatic m_step(input logic r, input logic k, input logic [3:0] d,
                        input logic s, input logic p, input logic dr);
    int entry;
    if (r) begin
      m_clear();
    end else begin
      case (m_state)
        0: if (k && d <= 4'd9) begin m_min = 0; m_sec = int'(d); m_state = 1; end
        1: begin
          if (p) begin m_min = 0; m_sec = 0; m_state = 0; end
          else if (s && !dr && (m_min + m_sec) != 0) begin m_phase = 0; m_state = 2; end
          else if (k && d <= 4'd9) begin
            entry = ((m_min * 100 + m_sec) * 10 + int'(d)) % 10000;
            m_min = entry / 100; m_sec = entry % 100;
          end
        end
        2: begin
          if (p || dr) m_state = 3;
          else begin
            m_phase++;
            if (m_phase == TPS) begin
              m_phase = 0;
              if (m_sec > 0) m_sec--; else begin m_min--; m_sec = 59; end
              if (m_min == 0 && m_sec == 0) begin m_state = 4; m_beep_left = BS * TPS; end
            end
          end
        end
        3: begin
          if (p) begin m_min = 0; m_sec = 0; m_state = 0; end
          else if (s && !dr) m_state = 2;
        end
        4: begin
          if (p) m_state = 0;
          else begin
            m_beep_left--;
            if (m_beep_left == 0) m_state = 0;
          end
        end
        default: m_clear();
      endcase
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        k;
    logic [3:0]  d;
    logic        s, p, dr;
    logic [2:0]  es;
    logic [15:0] et;
    logic        em;
  } vec_t;

  vec_t vecs[23];

  initial begin
    logic        dr_lvl;
    logic        r, k, s, p;
    logic [3:0]  d;

    vecs[0]  = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0}; // invalid digit in IDLE
    vecs[1]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0001, 1'b0};
    vecs[2]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0012, 1'b0};
    vecs[3]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0123, 1'b0};
    vecs[4]  = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 3'd1, 16'h1234, 1'b0};
    vecs[5]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 3'd1, 16'h2345, 1'b0}; // M10 discarded
    vecs[6]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 3'd1, 16'h2345, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd1, 16'h2345, 1'b0}; // start, door open
    vecs[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0};
    vecs[12] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0}; // start at 0000
    vecs[13] = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0009, 1'b0};
    vecs[14] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0}; // stop beats start
    vecs[15] = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0004, 1'b0};
    vecs[16] = '{1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 3'd2, 16'h0004, 1'b1}; // start beats key
    vecs[17] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 3'd3, 16'h0004, 1'b0};
    vecs[18] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd3, 16'h0004, 1'b0};
    vecs[19] = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 3'd3, 16'h0004, 1'b0};
    vecs[20] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 3'd2, 16'h0004, 1'b1};
    vecs[21] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 3'd3, 16'h0004, 1'b0};
    vecs[22] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};

    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset", 3'd0, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 23; i++) begin
      drive(1'b0, vecs[i].k, vecs[i].d, vecs[i].s, vecs[i].p, vecs[i].dr);
      chk($sformatf("vec%0d", i), vecs[i].es, vecs[i].et, vecs[i].em, 1'b0);
    end

    // Full 1:30 cook, countdown checkpoints, beep length.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    key(4'd1); key(4'd3); key(4'd0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("cook_entry", 3'd2, 16'h0130, 1'b1, 1'b0);
    idle_n(100, 1'b0);  chk("cook_100", 3'd2, 16'h0129, 1'b1, 1'b0);
    idle_n(3000, 1'b0); chk("cook_3100", 3'd2, 16'h0059, 1'b1, 1'b0);
    idle_n(5899, 1'b0); chk("cook_8999", 3'd2, 16'h0001, 1'b1, 1'b0);
    idle_n(1, 1'b0);    chk("done_entry", 3'd4, 16'h0000, 1'b0, 1'b1);
    idle_n(299, 1'b0);  chk("beep_last", 3'd4, 16'h0000, 1'b0, 1'b1);
    idle_n(1, 1'b0);    chk("beep_end", 3'd0, 16'h0000, 1'b0, 1'b0);

    // Minute and ten-minute borrow.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    key(4'd1); key(4'd0); key(4'd0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_n(100, 1'b0);  chk("borrow_min", 3'd2, 16'h0059, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_n(99, 1'b0);   chk("borrow_m10_pre", 3'd2, 16'h1000, 1'b1, 1'b0);
    idle_n(1, 1'b0);    chk("borrow_m10", 3'd2, 16'h0959, 1'b1, 1'b0);

    // Door open with tick at 40: held tick, 60 cycles to next decrement.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    key(4'd5);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_n(40, 1'b0);
    idle_n(1, 1'b1);    chk("door_pause", 3'd3, 16'h0005, 1'b0, 1'b0);
    idle_n(36, 1'b1);   chk("door_held", 3'd3, 16'h0005, 1'b0, 1'b0);
    idle_n(1, 1'b0);    chk("door_closed", 3'd3, 16'h0005, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("resume", 3'd2, 16'h0005, 1'b1, 1'b0);
    idle_n(59, 1'b0);   chk("resume_59", 3'd2, 16'h0005, 1'b1, 1'b0);
    idle_n(1, 1'b0);    chk("resume_60", 3'd2, 16'h0004, 1'b1, 1'b0);

    // Door opening on the wrap edge: no decrement, decrement right after resume.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    key(4'd2);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_n(99, 1'b0);
    idle_n(1, 1'b1);    chk("wrap_door", 3'd3, 16'h0002, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_n(1, 1'b0);    chk("wrap_resume", 3'd2, 16'h0001, 1'b1, 1'b0);

    // Reset mid-cook.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    key(4'd4); key(4'd2);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_n(30, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_cook", 3'd0, 16'h0000, 1'b0, 1'b0);

    // start+stop during DONE.
    key(4'd1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle_n(100, 1'b0);  chk("done_1s", 3'd4, 16'h0000, 1'b0, 1'b1);
    idle_n(10, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("done_stop", 3'd0, 16'h0000, 1'b0, 1'b0);

    // Randomized run against the reference model.
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    m_clear();
    dr_lvl = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      r = ($urandom_range(0, 2999) == 0);
      k = ($urandom_range(0, 14) == 0);
      d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      s = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 299) == 0) dr_lvl = ~dr_lvl;
      m_step(r, k, d, s, p, dr_lvl);
      drive(r, k, d, s, p, dr_lvl);
      chk("random", 3'(m_state), m_time(), (m_state == 2), (m_state == 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
